// File: rtl/mem_stage_sram.sv
// MEM pipeline stage bridging a 32-bit load/store onto a 16-bit asynchronous SRAM (two half-word phases).
// Optional build macro MEM_RANGE_CHECK_EN adds address range/alignment checking with addr_err.
module mem_stage_sram #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] MEM_BASE    = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Val_Rm,
  output logic [31:0] Mem_read_value,
  output logic        ready,
  output logic        addr_err,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [2:0] WC = 3'(WAIT_CYCLES);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic        is_wr;
  logic [16:0] idx;
  logic [31:0] wdata;
  logic [31:0] offs;
  logic        req, last, bad;

  assign req  = MEM_R_EN | MEM_W_EN;
  assign offs = ALU_result - MEM_BASE;
  assign last = (cnt == WC);

`ifdef MEM_RANGE_CHECK_EN
  logic err;
  assign bad      = (ALU_result < MEM_BASE) || (ALU_result[1:0] != 2'b00) || (|offs[31:19]);
  assign addr_err = err;

  always_ff @(posedge clk) begin
    if (rst)                       err <= 1'b0;
    else if (state == IDLE && req) err <= bad;
  end

  logic unused_offs;
  assign unused_offs = ^offs[1:0];
`else
  // Out-of-range addresses simply wrap into the 17-bit word index.
  assign bad      = 1'b0;
  assign addr_err = 1'b0;

  logic unused_offs;
  assign unused_offs = ^{offs[31:19], offs[1:0]};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req)  state_nxt = bad ? DONE : LO;
      LO:   if (last) state_nxt = HI;
      HI:   if (last) state_nxt = DONE;
      DONE:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      is_wr          <= 1'b0;
      idx            <= 17'd0;
      wdata          <= 32'd0;
      Mem_read_value <= 32'd0;
    end else begin
      state <= state_nxt;
      // counter restarts on every phase entry and idles at zero outside LO/HI
      if (state_nxt != state || state == IDLE || state == DONE) cnt <= 3'd0;
      else                                                      cnt <= cnt + 3'd1;

      if (state == IDLE && req) begin
        is_wr <= MEM_W_EN;
        idx   <= offs[18:2];
        wdata <= Val_Rm;
        if (bad && !MEM_W_EN) Mem_read_value <= 32'd0;
      end
      if (state == LO && last && !is_wr) Mem_read_value[15:0]  <= sram_dq_in;
      if (state == HI && last && !is_wr) Mem_read_value[31:16] <= sram_dq_in;
    end
  end

  always_comb begin
    SRAM_ADDR   = 18'd0;
    SRAM_WE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    if (state == LO || state == HI) begin
      SRAM_ADDR = {idx, state == HI};
      if (is_wr) begin
        SRAM_WE_N   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HI) ? wdata[31:16] : wdata[15:0];
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  assign ready = ~req | (state == DONE);

endmodule

// File: doc/mem_stage_sram.md
MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: extra SRAM wait cycles per half-word phase; legal range 0..7.
REQ-002 SHALL have parameter MEM_BASE, default 1024: byte address mapped to SRAM half-word 0.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- MEM_R_EN  in  1  load request from EXE/MEM register.
- MEM_W_EN  in  1  store request.
- ALU_result  in  32  byte address.
- Val_Rm  in  32  store data.
- Mem_read_value  out  32  registered load data.
- ready  out  1  0 = freeze pipeline.
- addr_err  out  1  range-check flag (REQ-019).
- SRAM_ADDR  out  18  half-word address.
- SRAM_WE_N  out  1  active-low write strobe.
- SRAM_OE_N  out  1  active-low output enable.
- sram_dq_out  out  16  write data.
- sram_dq_oe  out  1  drive enable for sram_dq_out.
- sram_dq_in  in  16  read data.

Function
REQ-005 SHALL implement FSM states IDLE, LO, HI, DONE.
REQ-006 SHALL use a 3-bit wait counter; each of LO and HI SHALL last exactly WAIT_CYCLES+1 cycles, with the counter cleared on phase entry.
REQ-007 SHALL make these transitions:
- IDLE -> LO when MEM_R_EN|MEM_W_EN.
- LO -> HI when the counter reaches WAIT_CYCLES.
- HI -> DONE likewise.
- DONE -> IDLE unconditionally.
REQ-008 SHALL compute the word index as (ALU_result - MEM_BASE) >> 2 (17 LSBs kept); SRAM_ADDR SHALL be {index,0} in LO and {index,1} in HI, and 0 otherwise.
REQ-009 SHALL give a write priority when MEM_W_EN and MEM_R_EN are both high; the access is then a store and Mem_read_value is not updated.
REQ-010 Store: in every LO/HI cycle, SRAM_WE_N=0 and sram_dq_oe=1; sram_dq_out SHALL be Val_Rm[15:0] in LO and Val_Rm[31:16] in HI.
REQ-011 Load: in every LO/HI cycle, SRAM_OE_N=0 and SRAM_WE_N=1; sram_dq_in SHALL be captured into Mem_read_value[15:0] on the last LO cycle and into [31:16] on the last HI cycle.
REQ-012 In IDLE and DONE, SRAM_WE_N=1, SRAM_OE_N=1 and sram_dq_oe=0.
REQ-013 ready SHALL be combinational: ready = ~(MEM_R_EN|MEM_W_EN) | (state==DONE).
REQ-014 Latency: for a request at cycle 0 (state IDLE), ready SHALL be 1 in cycle 2*WAIT_CYCLES+3 (DONE), and Mem_read_value SHALL be valid from that cycle.
REQ-015 Mem_read_value SHALL hold its value until the next load capture.
REQ-016 SHALL latch access type, address and store data on IDLE->LO; if the request drops mid-access, the access SHALL still complete unchanged.
REQ-017 A request still asserted in DONE SHALL NOT start a new access until the following IDLE cycle.

Reset
REQ-018 SHALL, in the cycle after rst=1 (including mid-access), be in state IDLE with counter=0, Mem_read_value=0, addr_err=0, SRAM_WE_N=1, SRAM_OE_N=1, sram_dq_oe=0 and SRAM_ADDR=0; an interrupted store is abandoned.

Configuration
REQ-019 With MEM_RANGE_CHECK_EN defined:
- addr_err SHALL register 1 on IDLE exit when ALU_result < MEM_BASE, ALU_result[1:0] != 0, or the index exceeds 17 bits.
- Such an access SHALL go IDLE -> DONE with no SRAM strobes; a load SHALL set Mem_read_value=0.
- addr_err SHALL clear on the next accepted access.
REQ-020 Without MEM_RANGE_CHECK_EN: addr_err SHALL be tied 0, there SHALL be no check, and addresses SHALL be truncated per REQ-008.

Verification (WAIT_CYCLES=1, MEM_BASE=1024 unless stated)
REQ-021 Store of Val_Rm=0xDEADBEEF to ALU_result=1028 -> SRAM_ADDR=2 with dq 0xBEEF for 2 cycles, then SRAM_ADDR=3 with dq 0xDEAD for 2 cycles, SRAM_WE_N=0 throughout; ready=1 in cycle 5.
REQ-022 Load from 1028 with the SRAM model returning the stored values -> Mem_read_value=0xDEADBEEF and ready=1 in cycle 5; exactly one access performed.
REQ-023 No requests for 10 cycles -> ready=1, SRAM_WE_N=1, SRAM_OE_N=1 and sram_dq_oe=0 throughout.
REQ-024 rst=1 in the first HI cycle of a store -> next cycle IDLE with SRAM_WE_N=1 and sram_dq_oe=0; a subsequent load of 1024 completes normally.
REQ-025 WAIT_CYCLES=0, load with MEM_R_EN=MEM_W_EN=1 -> treated as a store; ready=1 in cycle 3; Mem_read_value unchanged.
REQ-026 MEM_RANGE_CHECK_EN defined, load from 1026 -> addr_err=1, ready=1 in cycle 1, no SRAM strobes, Mem_read_value=0.
